// File: rtl/data_mem_controller.sv
// Purpose : round-robin arbiter serialising per-thread LSU read/write requests onto one data-memory port.
// Latency : grant edge drives the memory request; memory-ready edge raises the consumer ready; valid-drop edge returns to IDLE.
// Backpres: one memory transaction at a time; other consumers hold their valid until granted, memory stalls by withholding ready.
//
// Ports:
//   clk, reset (async, active-low)
//   consumer_read_*  / consumer_write_*  : per-consumer request (valid/address/data) and completion (ready/data)
//   mem_read_*       / mem_write_*       : single shared memory port, valid held until memory ready
// Build option: define DATA_MEM_CONTROLLER_WRITE_EN to enable the write path; without it write requests are
// never granted and all write outputs are tied low (ports kept for pin compatibility).
module data_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
    output logic                                      mem_read_valid,
    output logic [ADDR_BITS-1:0]                      mem_read_address,
    input  logic                                      mem_read_ready,
    input  logic [DATA_BITS-1:0]                      mem_read_data,
    output logic                                      mem_write_valid,
    output logic [ADDR_BITS-1:0]                      mem_write_address,
    output logic [DATA_BITS-1:0]                      mem_write_data,
    input  logic                                      mem_write_ready
);

    localparam int              PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [PTR_W:0]  NUM_C = (PTR_W+1)'(NUM_CONSUMERS);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_WAIT  = 2'd1;
    localparam logic [1:0] WRITE_WAIT = 2'd2;
    localparam logic [1:0] RELEASE    = 2'd3;

    logic [1:0]                               state_q;
    logic [PTR_W-1:0]                         rr_ptr_q;
    logic [PTR_W-1:0]                         gnt_q;
    logic                                     mem_read_valid_q;
    logic [ADDR_BITS-1:0]                     mem_read_address_q;
    logic [NUM_CONSUMERS-1:0]                 rd_rdy_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  rd_data_q;

    logic [NUM_CONSUMERS-1:0]                 wr_req;
    logic [PTR_W:0]                           cand_d;
    logic [PTR_W:0]                           inc_d;
    logic                                     gnt_found_d;
    logic [PTR_W-1:0]                         gnt_idx_d;
    logic                                     gnt_is_wr_d;
    logic [PTR_W-1:0]                         rr_ptr_d;

`ifdef DATA_MEM_CONTROLLER_WRITE_EN
    logic                                     is_wr_q;
    logic                                     mem_write_valid_q;
    logic [ADDR_BITS-1:0]                     mem_write_address_q;
    logic [DATA_BITS-1:0]                     mem_write_data_q;
    logic [NUM_CONSUMERS-1:0]                 wr_rdy_q;

    assign wr_req               = consumer_write_valid;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_write_ready = wr_rdy_q;
`else
    // Write path compiled out: requests are invisible to the arbiter.
    logic unused_wr;
    assign unused_wr            = ^{consumer_write_valid, consumer_write_address, consumer_write_data,
                                    mem_write_ready, gnt_is_wr_d};
    assign wr_req               = '0;
    assign mem_write_valid      = 1'b0;
    assign mem_write_address    = '0;
    assign mem_write_data       = '0;
    assign consumer_write_ready = '0;
`endif

    assign mem_read_valid      = mem_read_valid_q;
    assign mem_read_address    = mem_read_address_q;
    assign consumer_read_ready = rd_rdy_q;
    assign consumer_read_data  = rd_data_q;

    // Round-robin scan from rr_ptr; the first requester wins, reads before writes within a consumer.
    always_comb begin
        gnt_found_d = 1'b0;
        gnt_idx_d   = '0;
        gnt_is_wr_d = 1'b0;
        cand_d      = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            cand_d = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand_d >= NUM_C) begin
                cand_d = cand_d - NUM_C;
            end
            if (!gnt_found_d && (consumer_read_valid[cand_d[PTR_W-1:0]] || wr_req[cand_d[PTR_W-1:0]])) begin
                gnt_found_d = 1'b1;
                gnt_idx_d   = cand_d[PTR_W-1:0];
                gnt_is_wr_d = !consumer_read_valid[cand_d[PTR_W-1:0]];
            end
        end
    end

    // Pointer moves to the consumer after the winner, wrapping for non-power-of-two counts too.
    always_comb begin
        inc_d = {1'b0, gnt_idx_d} + (PTR_W+1)'(1);
        if (inc_d >= NUM_C) begin
            inc_d = '0;
        end
        rr_ptr_d = inc_d[PTR_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            gnt_q               <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            rd_rdy_q            <= '0;
            rd_data_q           <= '0;
`ifdef DATA_MEM_CONTROLLER_WRITE_EN
            is_wr_q             <= 1'b0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            wr_rdy_q            <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found_d) begin
                        gnt_q    <= gnt_idx_d;
                        rr_ptr_q <= rr_ptr_d;
`ifdef DATA_MEM_CONTROLLER_WRITE_EN
                        is_wr_q  <= gnt_is_wr_d;
                        if (gnt_is_wr_d) begin
                            mem_write_valid_q   <= 1'b1;
                            mem_write_address_q <= consumer_write_address[gnt_idx_d];
                            mem_write_data_q    <= consumer_write_data[gnt_idx_d];
                            state_q             <= WRITE_WAIT;
                        end else
`endif
                        begin
                            mem_read_valid_q   <= 1'b1;
                            mem_read_address_q <= consumer_read_address[gnt_idx_d];
                            state_q            <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_read_valid_q <= 1'b0;
                        rd_data_q[gnt_q] <= mem_read_data;
                        rd_rdy_q[gnt_q]  <= 1'b1;
                        state_q          <= RELEASE;
                    end
                end
                WRITE_WAIT: begin
`ifdef DATA_MEM_CONTROLLER_WRITE_EN
                    if (mem_write_ready) begin
                        mem_write_valid_q <= 1'b0;
                        wr_rdy_q[gnt_q]   <= 1'b1;
                        state_q           <= RELEASE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
                RELEASE: begin
                    // Ready is held until the granted consumer withdraws the matching valid.
`ifdef DATA_MEM_CONTROLLER_WRITE_EN
                    if (is_wr_q) begin
                        if (!consumer_write_valid[gnt_q]) begin
                            wr_rdy_q <= '0;
                            state_q  <= IDLE;
                        end
                    end else
`endif
                    if (!consumer_read_valid[gnt_q]) begin
                        rd_rdy_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, data memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, data memory word width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, number of requesting threads (one per compute_core thread LSU).
REQ-004 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  per-consumer read address.
- consumer_read_ready  out  NUM_CONSUMERS  per-consumer read completion.
- consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  per-consumer read data.
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
- consumer_write_address  in  NUM_CONSUMERS x ADDR_BITS  per-consumer write address.
- consumer_write_data  in  NUM_CONSUMERS x DATA_BITS  per-consumer write data.
- consumer_write_ready  out  NUM_CONSUMERS  per-consumer write completion.
- mem_read_valid  out  1  memory read request.
- mem_read_address  out  ADDR_BITS  memory read address.
- mem_read_ready  in  1  memory read done.
- mem_read_data  in  DATA_BITS  memory read data.
- mem_write_valid  out  1  memory write request.
- mem_write_address  out  ADDR_BITS  memory write address.
- mem_write_data  out  DATA_BITS  memory write data.
- mem_write_ready  in  1  memory write done.

Function
REQ-005 SHALL serialise all consumer requests onto the single memory port; at most one memory transaction outstanding.
REQ-006 SHALL implement FSM states IDLE, READ_WAIT, WRITE_WAIT, RELEASE.
REQ-007 IDLE: SHALL scan consumers round-robin starting at rr_ptr; first consumer with read or write valid is granted; if both asserted for that consumer, read wins.
REQ-008 On grant SHALL, next edge, register address (and write data), assert mem_read_valid or mem_write_valid, enter READ_WAIT or WRITE_WAIT, set rr_ptr = granted+1 modulo NUM_CONSUMERS (wraps NUM_CONSUMERS-1 -> 0).
REQ-009 IDLE with no valid: SHALL stay in IDLE, rr_ptr unchanged, no memory request.
REQ-010 READ_WAIT: SHALL hold mem_read_valid/address stable until mem_read_ready=1; on that edge SHALL deassert mem_read_valid, capture mem_read_data into consumer_read_data[granted], assert consumer_read_ready[granted], enter RELEASE.
REQ-011 WRITE_WAIT: same as REQ-010 with write signals; asserts consumer_write_ready[granted].
REQ-012 RELEASE: consumer ready SHALL stay asserted until the granted consumer deasserts the corresponding valid; on that edge ready deasserts and FSM returns to IDLE.
REQ-013 Minimum turnaround per request SHALL be: grant edge -> memory valid; ready edge -> consumer ready; valid-drop edge -> IDLE; next grant one cycle later.
REQ-014 consumer_read_data[i] SHALL hold last captured value until overwritten by next read for consumer i.
REQ-015 Changes in non-granted consumers' valid during a transaction SHALL be ignored until IDLE.
REQ-016 At most one bit of consumer_read_ready|consumer_write_ready SHALL be set at any time.

Reset
REQ-017 reset=0 SHALL asynchronously force: state IDLE, rr_ptr 0, all ready outputs 0, mem_read_valid 0, mem_write_valid 0, addresses 0, all data outputs 0.
REQ-018 Reset mid-transaction SHALL abandon it; no ready issued for it after release.

Configuration
REQ-019 Macro DATA_MEM_CONTROLLER_WRITE_EN defined: write path as specified.
REQ-020 Macro undefined: write requests never granted, WRITE_WAIT unreachable, mem_write_valid, mem_write_address, mem_write_data, consumer_write_ready tied 0; ports retained.

Verification
REQ-021 Consumer 2 read addr 0x10, memory returns 0xAB after 3 cycles -> mem_read_address=0x10, consumer_read_data[2]=0xAB, consumer_read_ready[2]=1 until valid drops.
REQ-022 All 4 consumers read simultaneously and held -> grants in order 0,1,2,3, then 0 again if re-requested; never two readys at once.
REQ-023 Consumer 1 asserts read and write together -> read served first, write served after release (with WRITE_EN).
REQ-024 Without DATA_MEM_CONTROLLER_WRITE_EN, consumer 0 writes 0x55 to 0x20 -> mem_write_valid stays 0, consumer_write_ready stays 0.
REQ-025 Reset=0 asserted during READ_WAIT -> all outputs 0 immediately; after release rr_ptr=0, next request served normally.
REQ-026 rr_ptr at 3, consumers 3 and 0 requesting -> 3 granted, then 0 (wrap).
